// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-client memory port arbiter.
//   - state_t  : arbiter FSM state encoding
//   - CL_*     : client identifiers (port 0 = data cache, port 1 = instruction cache)
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam logic CL_DCACHE = 1'b0;
  localparam logic CL_ICACHE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin grant, purely combinational.
//   req[1:0]  : request vector, bit N = client N pending
//   ptr       : preferred client when both request
//   gnt_valid : at least one request present
//   gnt_id    : granted client id
// The pointer is owned and advanced by the caller.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = CL_DCACHE;
    if (&req) begin
      gnt_id = ptr;
    end else if (req[1]) begin
      gnt_id = CL_ICACHE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between a data cache (client 0) and an
// instruction cache (client 1). One memory transaction is outstanding at a
// time; a client's write-back followed by its fill is serviced as an atomic
// pair; grants between clients are round-robin.
//   clk, reset (async, active-low)
//   cN_write_req/addr/data, cN_write_ack : write-back channel of client N
//   cN_read_req/addr, cN_read_data/ack   : fill channel of client N
//   mem_req/we/addr/wdata, mem_rdata/ack : backing-memory port
//   busy                                 : transaction in progress
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_write_req,
  input  logic [ADDR_W-1:0] c0_write_addr,
  input  logic [WIDTH-1:0]  c0_write_data,
  output logic              c0_write_ack,
  input  logic              c0_read_req,
  input  logic [ADDR_W-1:0] c0_read_addr,
  output logic [WIDTH-1:0]  c0_read_data,
  output logic              c0_read_ack,
  input  logic              c1_write_req,
  input  logic [ADDR_W-1:0] c1_write_addr,
  input  logic [WIDTH-1:0]  c1_write_data,
  output logic              c1_write_ack,
  input  logic              c1_read_req,
  input  logic [ADDR_W-1:0] c1_read_addr,
  output logic [WIDTH-1:0]  c1_read_data,
  output logic              c1_read_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  state_t            state_q, state_d;
  logic              owner_q;
  logic              rr_ptr_q;
  logic [1:0]        wack_q, rack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  rdata_q [2];

  logic [1:0]        wreq, rreq, pending;
  logic [ADDR_W-1:0] waddr [2];
  logic [ADDR_W-1:0] raddr [2];
  logic [WIDTH-1:0]  wdata [2];
  logic              gnt_valid, gnt_id;

  assign wreq     = {c1_write_req, c0_write_req};
  assign rreq     = {c1_read_req, c0_read_req};
  assign waddr[0] = c0_write_addr;
  assign waddr[1] = c1_write_addr;
  assign raddr[0] = c0_read_addr;
  assign raddr[1] = c1_read_addr;
  assign wdata[0] = c0_write_data;
  assign wdata[1] = c1_write_data;

  // A client whose ack is high this cycle may still show its request (it
  // drops on the ack edge); masking it prevents a spurious regrant.
  assign pending = (wreq | rreq) & ~wack_q & ~rack_q;

  rr_arb2 u_rr_arb2 (
    .req       (pending),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gnt_valid) state_d = wreq[gnt_id] ? ST_WRITE : ST_READ;
      ST_WRITE: if (mem_ack)   state_d = rreq[owner_q] ? ST_READ : ST_IDLE;
      ST_READ:  if (mem_ack)   state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= CL_DCACHE;
      rr_ptr_q   <= CL_DCACHE;
      wack_q     <= '0;
      rack_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      wack_q <= '0;
      rack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_q <= gnt_id;
            if (wreq[gnt_id]) begin
              addr_q  <= waddr[gnt_id];
              wdata_q <= wdata[gnt_id];
            end else begin
              addr_q  <= raddr[gnt_id];
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            wack_q[owner_q] <= 1'b1;
            // Fill of the same owner follows directly: the pair is atomic.
            if (rreq[owner_q]) addr_q   <= raddr[owner_q];
            else               rr_ptr_q <= ~owner_q;
          end
        end
        ST_READ: begin
          if (mem_ack) begin
            rdata_q[owner_q] <= mem_rdata;
            rack_q[owner_q]  <= 1'b1;
            rr_ptr_q         <= ~owner_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req      = (state_q != ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign mem_we       = (state_q == ST_WRITE);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign c0_write_ack = wack_q[0];
  assign c1_write_ack = wack_q[1];
  assign c0_read_ack  = rack_q[0];
  assign c1_read_ack  = rack_q[1];
  assign c0_read_data = rdata_q[0];
  assign c1_read_data = rdata_q[1];

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one backing-memory port between two cache clients: port 0 is the data cache, port 1 is the instruction cache.
- Each client exposes the cache memory-side interface: a write-back channel and a fill channel, each a level request with an ack.
- One memory transaction is outstanding at a time.
- A client's write-back followed by its fill is serviced as an atomic pair, so a cache that waits on write completion before accepting a fill never sees an interleaved fill.
- Between clients, grants are round-robin.

Parameters:
- WIDTH, 128, bits per cache line and per memory data word.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cN_write_req  in  1  client N (N=0,1) write-back request; level, held until ack.
- cN_write_addr  in  ADDR_W  write-back line address.
- cN_write_data  in  WIDTH  write-back line data.
- cN_write_ack  out  1  one-cycle pulse: write-back complete.
- cN_read_req  in  1  client N fill request; level, held until ack.
- cN_read_addr  in  ADDR_W  fill address.
- cN_read_data  out  WIDTH  fill data; valid while cN_read_ack=1 and held until the next fill to N.
- cN_read_ack  out  1  one-cycle pulse: fill complete.
- mem_req  out  1  memory transaction active.
- mem_we  out  1  1 = write, 0 = read; meaningful while mem_req=1.
- mem_addr  out  ADDR_W  latched transaction address.
- mem_wdata  out  WIDTH  latched write data.
- mem_rdata  in  WIDTH  read data; sampled on the cycle mem_ack=1 during a read.
- mem_ack  in  1  memory completes the current transaction; ignored while mem_req=0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE, rr_ptr=0 (client 0 preferred) and owner=0.
  - All acks, mem_req, mem_we and busy go to 0.
  - mem_addr, mem_wdata and cN_read_data go to 0.
  - An in-flight memory transaction is abandoned; no ack is issued for it.
- FSM states: IDLE, WRITE, READ. The owner register holds the granted client id.
- IDLE:
  - Client N is pending if (cN_write_req | cN_read_req) and neither cN ack output is high this cycle. The ack-cycle mask stops a request that drops on its ack from being regranted.
  - If both clients are pending, grant rr_ptr; otherwise grant the single pending client.
  - On the grant edge, latch owner. If the owner's write_req=1, latch write addr/data and go to WRITE. Otherwise latch read addr and go to READ.
- WRITE:
  - mem_req=1, mem_we=1.
  - On mem_ack, pulse cOwner_write_ack in the next cycle.
  - At the same edge, if cOwner_read_req=1, latch the read addr and go to READ with the same owner (atomic pair). Otherwise go to IDLE and set rr_ptr=~owner.
- READ:
  - mem_req=1, mem_we=0.
  - On mem_ack, register mem_rdata into cOwner_read_data, pulse cOwner_read_ack in the next cycle, go to IDLE and set rr_ptr=~owner.
- Latency:
  - A request seen at edge t gives mem_req=1 in cycle t+1.
  - mem_ack in cycle k gives the client ack in cycle k+1.
  - Minimum 2 cycles per transaction.
- Ordering: within an atomic pair the write ack always precedes the read ack by at least 1 cycle, even if memory acks in the first READ cycle.
- A client's request arriving mid-transaction of the other client waits.
- Bounded wait: at most one transaction pair of the other client.
- Latched addr/data are stable for the whole transaction, independent of later client input changes.
- Client-side requests that drop before grant are never serviced; requests dropping after grant do not abort the memory transaction, which still completes and acks.
- mem_ack held high continuously gives one transaction completion per state visit; there are no double acks.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_WRITE=2'd1, ST_READ=2'd2;
  - client id constants CL_DCACHE=1'b0, CL_ICACHE=1'b1.
- One natural sub-module, rr_arb2: a 2-requester round-robin grant.
  - Inputs: req[1:0], ptr.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational; the FSM owns ptr update.

Test Plan:
1. Reset mid-WRITE: drop reset while mem_req=1 -> all outputs 0 asynchronously; mem_ack in the following cycles produces no client ack; after reset release, c0 is served first.
2. Single fill: c1_read_req=1, addr 0x00001230; memory acks after 3 cycles with 0xDEADBEEF... -> mem_we=0, mem_addr=0x00001230, c1_read_ack pulse 1 cycle after mem_ack, c1_read_data=0xDEADBEEF... held afterwards.
3. Atomic evict+fill: c0 write 0x00002000 and read 0x00004000 together while c1 read is pending.
   - Required order: c0 write, then c0 read, then c1 read.
   - Acks in the same order; c1 is never granted between the c0 pair.
4. Round-robin: both clients assert read continuously for 4 transactions -> grants alternate 0,1,0,1 from reset.
5. Zero-wait memory: mem_ack tied to 1 -> each transaction takes exactly 2 cycles; exactly one ack per transaction; no regrant of a client in its ack cycle.
6. Input change after grant: modify c0_write_data after the grant -> mem_wdata keeps the latched value until mem_ack.
